// File: rtl/mxv_collect_pkg.sv
// Shared types and helpers for the matrix-vector result collector.
//   state_e    : collector state (idle / collecting results / draining to sink)
//   DEPTH_DEF  : default buffer depth (results per vector)
//   WIDTH_DEF  : default result width
//   clamp_n    : min(n, depth) for the requested result count
package mxv_collect_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain
  } state_e;

  function automatic logic [7:0] clamp_n(input logic [7:0] n, input int unsigned depth);
    if ({24'd0, n} > depth) begin
      return 8'(depth);
    end
    return n;
  endfunction

endpackage

// File: rtl/mxv_result_buf.sv
// DEPTH x WIDTH result register file with an internal write pointer.
//   clk, reset  : clock, asynchronous active-low reset (clears the write pointer only)
//   clr_i       : synchronous clear of the write pointer (start of a new vector)
//   wr_en_i     : store wr_data_i at the write pointer and advance it (wraps at DEPTH)
//   rd_idx_i    : read index; rd_data_o is a combinational read of the array
module mxv_result_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mxv_result_collector.sv
// Collects the N row results of one matrix-vector product from the engine's
// send pulses, then drains them in order over a valid/ready stream.
//   clk, reset          : clock, asynchronous active-low reset
//   n, n_valid          : arm a collection of min(n, DEPTH) results (n = 0 ignored)
//   send_in, result_in  : single-cycle result pulse from the engine
//   out_data/valid/last : output stream, out_ready from the sink
//   busy                : collecting or draining
//   done                : one-cycle pulse after the final beat is accepted
//   overflow            : sticky, a send pulse arrived outside collection
// Build option MXV_COLLECT_CSUM_EN: append a modulo-2^WIDTH sum beat after the
// results; out_last and done move to that beat.
module mxv_result_collector
  import mxv_collect_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       n,
  input  logic             n_valid,
  input  logic             send_in,
  input  logic [WIDTH-1:0] result_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  // One extra bit so counts and the read pointer can reach DEPTH.
  localparam int unsigned CNT_W = PTR_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_reg_q, n_reg_d;
  logic [CNT_W-1:0] last_idx;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             buf_clr, buf_wr;
  logic [WIDTH-1:0] rd_data;

`ifdef MXV_COLLECT_CSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;
  // Beat index n_reg is the checksum beat that follows the results.
  assign last_idx = n_reg_q;
  assign out_data = !out_valid ? '0 : (rd_ptr_q == n_reg_q) ? sum_q : rd_data;
`else
  assign last_idx = n_reg_q - CNT_W'(1);
  assign out_data = out_valid ? rd_data : '0;
`endif

  mxv_result_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (buf_clr),
    .wr_en_i  (buf_wr),
    .wr_data_i(result_in),
    .rd_idx_i (rd_ptr_q[PTR_W-1:0]),
    .rd_data_o(rd_data)
  );

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    n_reg_d    = n_reg_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
`ifdef MXV_COLLECT_CSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (n_valid && (n != 8'd0)) begin
          n_reg_d    = CNT_W'(clamp_n(n, DEPTH));
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          buf_clr    = 1'b1;
`ifdef MXV_COLLECT_CSUM_EN
          sum_d      = '0;
`endif
          state_d    = StCollect;
        end
      end
      StCollect: begin
        if (send_in) begin
          buf_wr  = 1'b1;
          count_d = count_q + CNT_W'(1);
`ifdef MXV_COLLECT_CSUM_EN
          sum_d   = sum_q + result_in;
`endif
          if (count_d == n_reg_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        out_last  = (rd_ptr_q == last_idx);
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + CNT_W'(1);
          if (out_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A pulse arriving outside collection is lost; setting wins over the arm-time clear.
    if (send_in && (state_q != StCollect)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      n_reg_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef MXV_COLLECT_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      n_reg_q    <= n_reg_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
`ifdef MXV_COLLECT_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mxv_result_collector.sv
// Directed bench for mxv_result_collector. A transaction-level model (queues of
// collected results and pending output beats) is checked against the DUT on every
// negative clock edge; literal beat lists pin the model per scenario.
module tb_mxv_result_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] n;
  logic       n_valid;
  logic       send_in;
  logic [7:0] result_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  mxv_result_collector dut (
    .clk      (clk),
    .reset    (reset),
    .n        (n),
    .n_valid  (n_valid),
    .send_in  (send_in),
    .result_in(result_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_stash[$];  // results gathered so far
  logic [7:0] m_q[$];      // beats still to be delivered
  logic       m_coll;
  logic       m_ovf;
  logic       m_done;
  logic [7:0] m_sum;
  int         m_n;
  logic       was_idle, was_coll;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stash.delete();
      m_q.delete();
      m_coll = 1'b0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      m_sum  = 8'h00;
      m_n    = 0;
    end else begin
      was_coll = m_coll;
      was_idle = !m_coll && (m_q.size() == 0);
      m_done   = 1'b0;
      if ((m_q.size() > 0) && out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
      if (was_idle && n_valid && (n != 8'd0)) begin
        m_n = (n > 8'd8) ? 8 : int'(n);
        m_stash.delete();
        m_sum  = 8'h00;
        m_ovf  = 1'b0;
        m_coll = 1'b1;
      end
      if (send_in) begin
        if (was_coll) begin
          m_stash.push_back(result_in);
          m_sum = m_sum + result_in;
          if (m_stash.size() == m_n) begin
            m_q = m_stash;
`ifdef MXV_COLLECT_CSUM_EN
            m_q.push_back(m_sum);
`endif
            m_coll = 1'b0;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] acc_d[$];
  logic       acc_l[$];

  always @(negedge clk) begin
    if (reset) begin
      chk("busy", busy, m_coll || (m_q.size() > 0));
      chk("out_valid", out_valid, m_q.size() > 0);
      chk("overflow", overflow, m_ovf);
      chk("done", done, m_done);
      if (m_q.size() > 0) begin
        chk("out_data", out_data, m_q[0]);
        chk("out_last", out_last, m_q.size() == 1);
        if (out_ready) begin
          acc_d.push_back(out_data);
          acc_l.push_back(out_last);
        end
      end else begin
        chk("out_data_idle", out_data, 0);
        chk("out_last_idle", out_last, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] e[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] nn);
    n = nn;
    n_valid = 1'b1;
    tick();
    n_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    send_in = 1'b1;
    result_in = v;
    tick();
    send_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_drain_timeout"}, busy, 0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_beats"}, acc_d.size(), e.size());
    for (int i = 0; i < e.size() && i < acc_d.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), acc_d[i], e[i]);
      chk($sformatf("%s_last%0d", tag, i), acc_l[i], i == e.size() - 1);
    end
    acc_d.delete();
    acc_l.delete();
    e.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    n = 8'd0;
    n_valid = 1'b0;
    send_in = 1'b0;
    result_in = 8'd0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    tick();

    // 1: n=4, sink always ready
    out_ready = 1'b1;
    arm(8'd4);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t1_first_valid", out_valid, 1);
    wait_idle("t1");
    chk("t1_done", done, 1);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_busy", busy, 0);
    e.push_back(8'h11); e.push_back(8'h22); e.push_back(8'h33); e.push_back(8'h44);
`ifdef MXV_COLLECT_CSUM_EN
    e.push_back(8'hAA);
`endif
    chk_log("t1");

    // 2: n=3 with back-pressure 1,0,0,1,1
    out_ready = 1'b0;
    arm(8'd3);
    send(8'h05); send(8'h06); send(8'h07);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b1; tick();
    wait_idle("t2");
    e.push_back(8'h05); e.push_back(8'h06); e.push_back(8'h07);
`ifdef MXV_COLLECT_CSUM_EN
    e.push_back(8'h12);
`endif
    chk_log("t2");

    // 3: dropped pulses, ignored n_valid, sticky overflow
    out_ready = 1'b0;
    send(8'h77);
    chk("t3_ovf_idle", overflow, 1);
    arm(8'd0);
    chk("t3_n0_ignored", busy, 0);
    arm(8'd2);
    chk("t3_ovf_cleared", overflow, 0);
    n = 8'd5; n_valid = 1'b1;  // ignored while collecting
    send(8'hA1);
    n_valid = 1'b0;
    send(8'hA2);
    send(8'h99);               // lands in DRAIN
    chk("t3_ovf_drain", overflow, 1);
    out_ready = 1'b1;
    wait_idle("t3a");
    chk("t3_ovf_sticky", overflow, 1);
    e.push_back(8'hA1); e.push_back(8'hA2);
`ifdef MXV_COLLECT_CSUM_EN
    e.push_back(8'h43);
`endif
    chk_log("t3a");
    arm(8'd2);
    chk("t3_ovf_rearm", overflow, 0);
    send(8'h01); send(8'h02);
    wait_idle("t3b");
    e.push_back(8'h01); e.push_back(8'h02);
`ifdef MXV_COLLECT_CSUM_EN
    e.push_back(8'h03);
`endif
    chk_log("t3b");

    // 4: n=12 clamps to 8
    arm(8'd12);
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("t4_drain_after_8", out_valid, 1);
    wait_idle("t4");
    for (int i = 1; i <= 8; i++) e.push_back(8'(i));
`ifdef MXV_COLLECT_CSUM_EN
    e.push_back(8'h24);
`endif
    chk_log("t4");

    // 5: asynchronous reset mid-drain, then a fresh vector
    out_ready = 1'b0;
    arm(8'd4);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_busy", busy, 0);
    #3 reset = 1'b1;
    e.push_back(8'h31); e.push_back(8'h32);
    acc_l[acc_l.size() - 1] = 1'b1;  // pre-reset log ends here; only beat values matter
    chk_log("t5a");
    tick();
    out_ready = 1'b1;
    arm(8'd2);
    send(8'h0A); send(8'h0B);
    wait_idle("t5b");
    e.push_back(8'h0A); e.push_back(8'h0B);
`ifdef MXV_COLLECT_CSUM_EN
    e.push_back(8'h15);
`endif
    chk_log("t5b");

`ifdef MXV_COLLECT_CSUM_EN
    // 6: checksum wraps modulo 256
    arm(8'd2);
    send(8'hF0); send(8'h20);
    wait_idle("t6");
    e.push_back(8'hF0); e.push_back(8'h20); e.push_back(8'h10);
    chk_log("t6");
`endif

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
